mul_seq: RTL and testbench

Sequential 32×32 → 64-bit unsigned multiplier controller for the ALU. It sequences the ALU's 32-bit ripple adder (`sum` module, one instance owned by this block) through 32 shift-and-add steps, one step per clock. Operands enter and the product leaves through valid/ready handshakes. It sits beside the combinational ALU operations and serves the multiply opcode.

---
 rtl/mul_seq.sv | 94 +++++++++
 tb/tb_mul_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential 32x32 -> 64 unsigned shift-and-add multiplier.
// One ripple-adder step per clock, valid/ready on both operand and product sides.

module sum (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c
);
  // Ripple chain as a loop-carried variable so the carry net is not one self-referencing vector
  always_comb begin
    logic cy;
    cy = 1'b0;
    s  = '0;
    for (int i = 0; i < 32; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c = cy;
  end
endmodule

module mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] m, p_hi, p_lo;
  logic [5:0]  cnt;
  logic [31:0] add_s;
  logic        add_c;

  sum u_sum (
    .a (p_hi),
    .b (p_lo[0] ? m : 32'h0),
    .s (add_s),
    .c (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = RUN;
      RUN:     if (cnt == 6'd31)  state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Carry-out lands in P_hi[31]; dropping it breaks multiplicands >= 2^31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m    <= A;
          p_lo <= B;
          p_hi <= '0;
          cnt  <= '0;
        end
        RUN: begin
          p_hi <= {add_c, add_s[31:1]};
          p_lo <= {add_s[0], p_lo[31:1]};
          cnt  <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = {p_hi, p_lo};
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed table, corner sequences and
// random operands against plain 64-bit multiplication.

module tb_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one job, watch latency and in_ready through RUN, hold backpressure, then drain
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input int hold, input bit poke, input string nm);
    int lat;
    bit rdy_seen;
    logic [63:0] p0;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      if (poke && lat == 5) begin A = 32'd1; B = 32'd1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd32);
    chk({nm, " in_ready low in RUN"}, 64'(rdy_seen), 64'd0);
    chk({nm, " product"}, product, exp);
    p0 = product;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " hold product"}, product, p0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " back to idle"}, {61'd0, in_ready, out_valid, busy}, 64'b100);
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] ra, rb;
    bit seen;

    tbl[0] = '{32'd3,          32'd5,          64'h000000000000000F};
    tbl[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    tbl[2] = '{32'h80000000,   32'd2,          64'h0000000100000000};
    tbl[3] = '{32'd1,          32'hFFFFFFFF,   64'h00000000FFFFFFFF};
    tbl[4] = '{32'h00010000,   32'h00010000,   64'h0000000100000000};
    tbl[5] = '{32'hFFFFFFFF,   32'd1,          64'h00000000FFFFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    chk("reset product",   product,        64'd0);

    foreach (tbl[i]) run_job(tbl[i].a, tbl[i].b, tbl[i].exp, 0, 1'b0, $sformatf("tbl%0d", i));

    run_job(32'd0, 32'h12345678, 64'd0, 10, 1'b0, "zero_bp");
    run_job(32'd7, 32'd9, 64'd63, 0, 1'b1, "ignore_in");

    // Asynchronous reset in the middle of step 10
    @(negedge clk);
    A = 32'd100; B = 32'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst outputs", {61'd0, in_ready, out_valid, busy}, 64'b100);
    chk("midrst product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no out_valid", 64'(seen), 64'd0);
    run_job(32'd6, 32'd7, 64'd42, 0, 1'b0, "post_rst");

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n < 4) ra[31] = 1'b1;
      run_job(ra, rb, 64'(ra) * 64'(rb), n % 3, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
